// File: rtl/unified_mem_arbiter_if.sv
// Requester, response and memory-side signals of the unified memory arbiter.
// The arbiter uses the slave view; the pipeline stages and memory model use the master view.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_ack;
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [DATA_W-1:0] d_rdata;
  logic              d_ack;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_rdata, if_ack, d_rdata, d_ack, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between instruction fetch and
// data access; each grant runs a fixed LATENCY-cycle access followed by a one-cycle ack.

module unified_mem_arbiter_chk (
  input logic clock,
  input logic reset,
  input logic if_ack,
  input logic d_ack,
  input logic mem_en,
  input logic mem_we,
  input logic busy
);
  a_acks_exclusive : assert property (@(posedge clock) disable iff (reset) !(if_ack && d_ack));
  a_if_ack_pulse   : assert property (@(posedge clock) disable iff (reset) if_ack |=> !if_ack);
  a_d_ack_pulse    : assert property (@(posedge clock) disable iff (reset) d_ack |=> !d_ack);
  a_ack_while_busy : assert property (@(posedge clock) disable iff (reset) (if_ack || d_ack) |-> busy);
  a_en_while_busy  : assert property (@(posedge clock) disable iff (reset) mem_en |-> busy);
  a_we_needs_en    : assert property (@(posedge clock) disable iff (reset) mem_we |-> mem_en);
endmodule

module unified_mem_arbiter #(
  parameter int LATENCY = 2,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32
) (
  input logic                  clock,
  input logic                  reset,
  unified_mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } state_t;

  typedef enum logic {
    PORT_I = 1'b0,
    PORT_D = 1'b1
  } port_t;

  localparam logic [3:0] CNT_LOAD = 4'(LATENCY) - 4'd1;

  state_t            state_r, state_s;
  port_t             ptr_r, ptr_s;
  port_t             port_r, port_s;
  port_t             grant_port_s;
  logic              grant_s;
  logic [3:0]        cnt_r, cnt_s;
  logic [ADDR_W-1:0] addr_r, addr_s;
  logic              we_r, we_s;
  logic [DATA_W-1:0] wdata_r, wdata_s;
  logic [DATA_W-1:0] if_rdata_r, if_rdata_s;
  logic [DATA_W-1:0] d_rdata_r, d_rdata_s;
  logic              if_ack_r, if_ack_s;
  logic              d_ack_r, d_ack_s;
  logic              mem_en_r, mem_en_s;
  logic              mem_we_r, mem_we_s;
  logic              busy_r, busy_s;

  // Next-state and next-output logic; every output is computed here and registered below.
  always_comb begin
    state_s      = state_r;
    ptr_s        = ptr_r;
    port_s       = port_r;
    cnt_s        = cnt_r;
    addr_s       = addr_r;
    we_s         = we_r;
    wdata_s      = wdata_r;
    if_rdata_s   = if_rdata_r;
    d_rdata_s    = d_rdata_r;
    if_ack_s     = 1'b0;
    d_ack_s      = 1'b0;
    mem_en_s     = 1'b0;
    mem_we_s     = 1'b0;
    busy_s       = 1'b0;
    grant_s      = 1'b0;
    grant_port_s = PORT_D;

    case (state_r)
      ST_IDLE: begin
        if (bus.if_req && bus.d_req) begin
          grant_s      = 1'b1;
          grant_port_s = ptr_r;
        end else if (bus.d_req) begin
          grant_s      = 1'b1;
          grant_port_s = PORT_D;
        end else if (bus.if_req) begin
          grant_s      = 1'b1;
          grant_port_s = PORT_I;
        end else begin
          grant_s      = 1'b0;
          grant_port_s = ptr_r;
        end

        if (grant_s) begin
          port_s = grant_port_s;
          ptr_s  = (grant_port_s == PORT_D) ? PORT_I : PORT_D;
          if (grant_port_s == PORT_D) begin
            addr_s  = bus.d_addr;
            we_s    = bus.d_we;
            wdata_s = bus.d_wdata;
          end else begin
            addr_s  = bus.if_addr;
            we_s    = 1'b0;
            wdata_s = wdata_r;
          end
          cnt_s    = CNT_LOAD;
          state_s  = ST_ACCESS;
          mem_en_s = 1'b1;
          mem_we_s = we_s;
          busy_s   = 1'b1;
        end else begin
          state_s = ST_IDLE;
        end
      end

      ST_ACCESS: begin
        busy_s = 1'b1;
        // Final access cycle: memory data is valid now, ack goes out next cycle.
        if (cnt_r == 4'd0) begin
          state_s = ST_DONE;
          if (port_r == PORT_D) begin
            d_ack_s = 1'b1;
            if (!we_r) begin
              d_rdata_s = bus.mem_rdata;
            end else begin
              d_rdata_s = d_rdata_r;
            end
          end else begin
            if_ack_s = 1'b1;
            if (!we_r) begin
              if_rdata_s = bus.mem_rdata;
            end else begin
              if_rdata_s = if_rdata_r;
            end
          end
        end else begin
          cnt_s    = cnt_r - 4'd1;
          mem_en_s = 1'b1;
          mem_we_s = we_r;
        end
      end

      ST_DONE: begin
        state_s = ST_IDLE;
      end

      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // State and output registers; reset aborts any access and clears read data.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_r    <= ST_IDLE;
      ptr_r      <= PORT_D;
      port_r     <= PORT_I;
      cnt_r      <= 4'd0;
      addr_r     <= {ADDR_W{1'b0}};
      we_r       <= 1'b0;
      wdata_r    <= {DATA_W{1'b0}};
      if_rdata_r <= {DATA_W{1'b0}};
      d_rdata_r  <= {DATA_W{1'b0}};
      if_ack_r   <= 1'b0;
      d_ack_r    <= 1'b0;
      mem_en_r   <= 1'b0;
      mem_we_r   <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      ptr_r      <= ptr_s;
      port_r     <= port_s;
      cnt_r      <= cnt_s;
      addr_r     <= addr_s;
      we_r       <= we_s;
      wdata_r    <= wdata_s;
      if_rdata_r <= if_rdata_s;
      d_rdata_r  <= d_rdata_s;
      if_ack_r   <= if_ack_s;
      d_ack_r    <= d_ack_s;
      mem_en_r   <= mem_en_s;
      mem_we_r   <= mem_we_s;
      busy_r     <= busy_s;
    end
  end

  assign bus.if_rdata  = if_rdata_r;
  assign bus.if_ack    = if_ack_r;
  assign bus.d_rdata   = d_rdata_r;
  assign bus.d_ack     = d_ack_r;
  assign bus.mem_en    = mem_en_r;
  assign bus.mem_we    = mem_we_r;
  assign bus.mem_addr  = addr_r;
  assign bus.mem_wdata = wdata_r;
  assign bus.busy      = busy_r;

  unified_mem_arbiter_chk u_chk (
    .clock  (clock),
    .reset  (reset),
    .if_ack (if_ack_r),
    .d_ack  (d_ack_r),
    .mem_en (mem_en_r),
    .mem_we (mem_we_r),
    .busy   (busy_r)
  );
endmodule
